// File: rtl/serial_block_collector.sv
// Serial-to-parallel block collector with a collect buffer and an output holding register.
// Stalls the serial source when a full block waits behind an unconsumed output block.
module serial_block_collector #(
    parameter int WIDTH     = 64,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   clear_b,
    input  logic                   serial_in,
    input  logic                   serial_valid,
    output logic                   serial_ready,
    output logic [WIDTH-1:0]       block_out,
    output logic                   block_valid,
    input  logic                   block_ready,
    output logic [$clog2(WIDTH):0] bit_count
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] col_buf, col_buf_nx, shifted, block_out_nx;
    logic [CW-1:0]    count_nx;
    logic             block_valid_nx;
    logic             bit_acc, blk_acc, out_free;

    // Handshakes: a transfer happens on any rising edge where valid and ready
    // are both high; valid never depends on ready on either side.
    assign serial_ready = (state == COLLECT);
    assign bit_acc      = serial_valid & serial_ready;
    assign blk_acc      = block_valid & block_ready;
    assign out_free     = ~block_valid | blk_acc;

    if (MSB_FIRST) begin : g_msb_first
        assign shifted = {col_buf[WIDTH-2:0], serial_in};
    end else begin : g_lsb_first
        assign shifted = {serial_in, col_buf[WIDTH-1:1]};
    end

    always_comb begin
        state_nx       = state;
        col_buf_nx     = col_buf;
        count_nx       = bit_count;
        block_out_nx   = block_out;
        block_valid_nx = block_valid;
        if (blk_acc) begin
            block_valid_nx = 1'b0;
        end
        case (state)
            COLLECT: begin
                if (bit_acc) begin
                    col_buf_nx = shifted;
                    count_nx   = bit_count + CW'(1);
                    if (bit_count == CW'(WIDTH - 1)) begin
                        if (out_free) begin
                            block_out_nx   = shifted;
                            block_valid_nx = 1'b1;
                            count_nx       = '0;
                        end else begin
                            state_nx = STALL;
                        end
                    end
                end
            end
            STALL: begin
                // A full block is parked in col_buf; it moves out the moment the
                // holding register is consumed, keeping block_valid high.
                if (blk_acc) begin
                    block_out_nx   = col_buf;
                    block_valid_nx = 1'b1;
                    count_nx       = '0;
                    state_nx       = COLLECT;
                end
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge clear_b) begin
        if (clear_b) begin
            state       <= COLLECT;
            col_buf     <= '0;
            bit_count   <= '0;
            block_out   <= '0;
            block_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            col_buf     <= col_buf_nx;
            bit_count   <= count_nx;
            block_out   <= block_out_nx;
            block_valid <= block_valid_nx;
        end
    end

endmodule

// File: tb/tb_serial_block_collector.sv
// Bench for serial_block_collector: WIDTH=4 (both bit orders) and WIDTH=64 instances,
// queue-based reference model compared every cycle, plus directed literal expectations.
module tb_serial_block_collector;

    logic clk;
    logic clear_b;
    logic si4, sv4, br4;
    logic si64, sv64, br64;

    logic        rdy4, v4, rdy4l, v4l, rdy64, v64;
    logic [3:0]  out4, out4l;
    logic [2:0]  cnt4, cnt4l;
    logic [63:0] out64;
    logic [6:0]  cnt64;

    int checks = 0;
    int failures = 0;
    int consumed64 = 0;

    // Model state: bits waiting in the collect buffer, plus the holding register.
    bit          mq0[$];
    bit          mq1[$];
    logic        mhv[2];
    logic [63:0] mho[2];
    logic [63:0] exp_q[$];

    serial_block_collector #(.WIDTH(4), .MSB_FIRST(1'b1)) d4 (
        .clk(clk), .clear_b(clear_b), .serial_in(si4), .serial_valid(sv4),
        .serial_ready(rdy4), .block_out(out4), .block_valid(v4),
        .block_ready(br4), .bit_count(cnt4)
    );

    serial_block_collector #(.WIDTH(4), .MSB_FIRST(1'b0)) d4l (
        .clk(clk), .clear_b(clear_b), .serial_in(si4), .serial_valid(sv4),
        .serial_ready(rdy4l), .block_out(out4l), .block_valid(v4l),
        .block_ready(br4), .bit_count(cnt4l)
    );

    serial_block_collector #(.WIDTH(64), .MSB_FIRST(1'b1)) d64 (
        .clk(clk), .clear_b(clear_b), .serial_in(si64), .serial_valid(sv64),
        .serial_ready(rdy64), .block_out(out64), .block_valid(v64),
        .block_ready(br64), .bit_count(cnt64)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // First received bit is the most significant bit of the block.
    function automatic logic [63:0] pack_msb(input bit q[$], input int w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < w; i++) v[w-1-i] = q[i];
        return v;
    endfunction

    function automatic logic [3:0] rev4(input logic [63:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = v[3-i];
        return r;
    endfunction

    task automatic model_step(input int k, input int w, input logic si,
                              input logic sv, input logic br);
        bit   q[$];
        logic stalled, acc;
        if (k == 0) q = mq0; else q = mq1;
        stalled = (q.size() == w);
        acc     = mhv[k] && br;
        if (acc) mhv[k] = 1'b0;
        if (stalled) begin
            if (acc) begin
                mho[k] = pack_msb(q, w);
                mhv[k] = 1'b1;
                q.delete();
            end
        end else if (sv) begin
            q.push_back(si);
            if (q.size() == w) begin
                if (k == 1) exp_q.push_back(pack_msb(q, w));
                if (!mhv[k]) begin
                    mho[k] = pack_msb(q, w);
                    mhv[k] = 1'b1;
                    q.delete();
                end
            end
        end
        if (k == 0) mq0 = q; else mq1 = q;
    endtask

    always @(posedge clk or posedge clear_b) begin
        if (clear_b) begin
            mq0.delete();
            mq1.delete();
            exp_q.delete();
            mhv[0] = 1'b0; mhv[1] = 1'b0;
            mho[0] = '0;   mho[1] = '0;
        end else begin
            model_step(0, 4, si4, sv4, br4);
            model_step(1, 64, si64, sv64, br64);
        end
    end

    // Compare process: outputs against the model every cycle, plus the block scoreboard.
    always @(negedge clk) begin
        chk("w4_ready",  rdy4,  64'(mq0.size() != 4));
        chk("w4_count",  cnt4,  64'(mq0.size()));
        chk("w4_valid",  v4,    mhv[0]);
        chk("w4_out",    out4,  mho[0][3:0]);
        chk("w4l_ready", rdy4l, 64'(mq0.size() != 4));
        chk("w4l_count", cnt4l, 64'(mq0.size()));
        chk("w4l_valid", v4l,   mhv[0]);
        chk("w4l_out",   out4l, rev4(mho[0]));
        chk("w64_ready", rdy64, 64'(mq1.size() != 64));
        chk("w64_count", cnt64, 64'(mq1.size()));
        chk("w64_valid", v64,   mhv[1]);
        chk("w64_out",   out64, mho[1]);
        if (v64 && br64 && !clear_b) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_block", out64, 64'hx);
            end else begin
                chk("sb_block", out64, exp_q.pop_front());
            end
            consumed64++;
        end
    end

    // driver tasks: inputs change shortly after the rising edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send4(input logic b);
        sv4 = 1'b1;
        si4 = b;
        cyc();
    endtask

    logic [3:0] pat;

    initial begin
        clear_b = 1'b1;
        si4 = 0; sv4 = 0; br4 = 0;
        si64 = 0; sv64 = 0; br64 = 0;
        repeat (2) cyc();
        clear_b = 1'b0;
        cyc();
        chk("rst_valid", v4, 0);
        chk("rst_count", cnt4, 0);
        chk("rst_ready", rdy4, 1);
        chk("rst_out",   out4, 0);

        // Consecutive bits, consumer always ready
        br4 = 1'b1;
        pat = 4'b1011;
        for (int i = 3; i >= 0; i--) send4(pat[i]);
        sv4 = 1'b0;
        chk("s2_valid", v4, 1);
        chk("s2_out_msb", out4, 4'b1011);
        chk("s2_out_lsb", out4l, 4'b1101);
        cyc();
        chk("s2_valid_one_cycle", v4, 0);

        // Backpressure: held block, stall, junk ignored, back-to-back reload
        br4 = 1'b0;
        pat = 4'b1011;
        for (int i = 3; i >= 0; i--) send4(pat[i]);
        pat = 4'b0110;
        for (int i = 3; i >= 0; i--) send4(pat[i]);
        chk("s3_stall_ready", rdy4, 0);
        chk("s3_stall_count", cnt4, 4);
        chk("s3_held_out", out4, 4'b1011);
        repeat (2) send4(1'($urandom_range(0, 1)));
        sv4 = 1'b0;
        chk("s3_junk_count", cnt4, 4);
        chk("s3_junk_out", out4, 4'b1011);
        br4 = 1'b1;
        cyc();
        br4 = 1'b0;
        chk("s3_reload_out", out4, 4'b0110);
        chk("s3_reload_valid", v4, 1);
        chk("s3_reload_ready", rdy4, 1);
        chk("s3_reload_count", cnt4, 0);
        br4 = 1'b1;
        cyc();
        chk("s3_drained", v4, 0);

        // Gapped valid: idle cycles must not shift
        pat = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            send4(pat[i]);
            if (i == 0) chk("s4_out", out4, 4'b1001);
            sv4 = 1'b0;
            si4 = 1'($urandom_range(0, 1));
            cyc();
        end

        // Mid-block asynchronous reset discards held and partial blocks
        br4 = 1'b0;
        pat = 4'b1100;
        for (int i = 3; i >= 0; i--) send4(pat[i]);
        send4(1'b1);
        send4(1'b0);
        sv4 = 1'b0;
        chk("s5_pre_count", cnt4, 2);
        clear_b = 1'b1;
        #1;
        chk("s5_rst_valid", v4, 0);
        chk("s5_rst_count", cnt4, 0);
        chk("s5_rst_ready", rdy4, 1);
        chk("s5_rst_out",   out4, 0);
        cyc();
        clear_b = 1'b0;
        br4 = 1'b1;
        pat = 4'b0111;
        for (int i = 3; i >= 0; i--) send4(pat[i]);
        sv4 = 1'b0;
        chk("s5_out", out4, 4'b0111);
        cyc();

        // Random streams: 64-bit continuous, 50% consumer; 4-bit fully random
        for (int c = 0; c < 20000 && consumed64 < 100; c++) begin
            sv64 = 1'b1;
            si64 = 1'($urandom_range(0, 1));
            br64 = 1'($urandom_range(0, 1));
            sv4  = 1'($urandom_range(0, 1));
            si4  = 1'($urandom_range(0, 1));
            br4  = 1'($urandom_range(0, 1));
            cyc();
        end
        sv64 = 1'b0; br64 = 1'b0; sv4 = 1'b0; br4 = 1'b0;
        cyc();
        chk("s6_blocks_consumed", 64'(consumed64 >= 100), 1);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
